// File: rtl/fetch_align.sv
// -----------------------------------------------------------------------------
// fetch_align
//
// Instruction fetch / realign stage for an RV32IC pipeline. Issues word-aligned
// fetches to instruction memory, buffers the returned halfwords in a 4-entry
// queue and presents one 16-bit (compressed, zero-extended) or 32-bit
// instruction per valid/ready handshake. A 32-bit instruction may straddle a
// word boundary; it is simply the head two halfwords of the queue.
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous, active-high reset
//   redirect_valid  taken branch/jump from later stages; flushes this stage
//   redirect_pc     redirect target (bit 0 ignored, bit 1 selects upper half)
//   imem_req        fetch request, always accepted by memory
//   imem_addr       word-aligned fetch address
//   imem_rvalid     response valid, exactly one cycle after each request
//   imem_rdata      response word, halfword at addr+0 in [15:0]
//   out_valid       instruction available
//   out_ready       decode accepts the instruction
//   out_pc          PC of the presented instruction
//   out_instr       presented instruction (compressed ones in [15:0])
//   out_compressed  1 when out_instr[1:0] != 2'b11
// -----------------------------------------------------------------------------
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_compressed
);

    localparam int QDEPTH = 4;

    // Halfword queue; entry 0 is always the head. Popping shifts the queue
    // down, pushing writes just above the surviving entries.
    logic [15:0] q_reg  [QDEPTH];
    logic [15:0] q_next [QDEPTH];
    logic [2:0]  count_reg;
    logic [2:0]  count_next;
    logic [31:0] head_pc_reg;
    logic [31:0] fetch_pc_reg;
    logic        drop_lo_reg;   // next accepted response only contributes [31:16]
    logic        kill_reg;      // outstanding response belongs to a flushed stream
    logic        inflight_reg;  // a request was issued last cycle

    logic        head_is32;
    logic        enough;
    logic        present;
    logic        fire;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic        resp_ok;
    logic [15:0] push_lo;
    logic [15:0] push_hi;
    logic [2:0]  base;
    logic [3:0]  level;
    logic        fetch_ok;
    logic [31:0] redirect_word;
    logic        unused_redirect_bit0;

    assign unused_redirect_bit0 = redirect_pc[0];

    // -------------------------------------------------------------------------
    // Instruction extraction
    // -------------------------------------------------------------------------
    assign head_is32 = (q_reg[0][1:0] == 2'b11);
    assign enough    = head_is32 ? (count_reg >= 3'd2) : (count_reg >= 3'd1);
    assign present   = enough && !rst;

    assign out_valid      = enough && !redirect_valid && !rst;
    assign fire           = out_valid && out_ready;
    assign out_pc         = rst ? RESET_PC : head_pc_reg;
    assign out_compressed = present && !head_is32;

    always_comb begin
        out_instr = 32'h0000_0000;
        if (present) begin
            if (head_is32) begin
                out_instr = {q_reg[1], q_reg[0]};
            end else begin
                out_instr = {16'h0000, q_reg[0]};
            end
        end
    end

    assign pop_n = fire ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

    // -------------------------------------------------------------------------
    // Response acceptance
    // -------------------------------------------------------------------------
    // A redirect or reset in the same cycle overrides the push entirely (the
    // sequential block ignores q_next then), which is how the beat belonging
    // to a pre-redirect request is dropped.
    assign resp_ok = imem_rvalid && inflight_reg && !kill_reg;
    assign push_n  = resp_ok ? (drop_lo_reg ? 2'd1 : 2'd2) : 2'd0;
    assign push_lo = drop_lo_reg ? imem_rdata[31:16] : imem_rdata[15:0];
    assign push_hi = imem_rdata[31:16];

    // Entries surviving this cycle's pop; pops never exceed the count
    // because out_valid requires enough entries for the head instruction.
    assign base       = count_reg - {1'b0, pop_n};
    assign level      = {1'b0, base} + {2'b00, push_n};
    assign count_next = level[2:0];

    // A request issued now returns next cycle with up to two halfwords.
    // Without counting on any future pop, the queue must then still have room
    // for a full word: occupancy after this cycle must be at most 2.
    assign fetch_ok = (level <= 4'd2);

    assign redirect_word = {redirect_pc[31:2], 2'b00};
    assign imem_req      = !rst && (redirect_valid || fetch_ok);
    assign imem_addr     = redirect_valid ? redirect_word : fetch_pc_reg;

    // -------------------------------------------------------------------------
    // Queue next-state, one entry per generate iteration
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            logic [15:0] shift1;
            logic [15:0] shift2;

            if (gi + 1 < QDEPTH) begin : g_s1
                assign shift1 = q_reg[gi + 1];
            end else begin : g_s1_zero
                assign shift1 = 16'h0000;
            end

            if (gi + 2 < QDEPTH) begin : g_s2
                assign shift2 = q_reg[gi + 2];
            end else begin : g_s2_zero
                assign shift2 = 16'h0000;
            end

            assign q_next[gi] =
                ((push_n != 2'd0) && ({1'b0, base} == 4'(gi)))          ? push_lo :
                ((push_n == 2'd2) && ({1'b0, base} + 4'd1 == 4'(gi)))   ? push_hi :
                (pop_n == 2'd2)                                        ? shift2  :
                (pop_n == 2'd1)                                        ? shift1  :
                                                                         q_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_reg[i] <= 16'h0000;
            end
            count_reg    <= 3'd0;
            head_pc_reg  <= RESET_PC;
            fetch_pc_reg <= RESET_PC;
            drop_lo_reg  <= 1'b0;
            kill_reg     <= 1'b0;
            inflight_reg <= 1'b0;
        end else if (redirect_valid) begin
            // The request issued this cycle is the redirect's own fetch, so
            // the beat arriving next cycle is wanted; only the beat arriving
            // in this very cycle is stale, and it is never pushed.
            count_reg    <= 3'd0;
            head_pc_reg  <= {redirect_pc[31:1], 1'b0};
            fetch_pc_reg <= redirect_word + 32'd4;
            drop_lo_reg  <= redirect_pc[1];
            kill_reg     <= 1'b0;
            inflight_reg <= 1'b1;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_reg[i] <= q_next[i];
            end
            count_reg <= count_next;
            if (fire) begin
                head_pc_reg <= head_pc_reg + (head_is32 ? 32'd4 : 32'd2);
            end
            if (imem_req) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            if (resp_ok) begin
                drop_lo_reg <= 1'b0;
            end
            kill_reg     <= 1'b0;
            inflight_reg <= imem_req;
        end
    end

    // Occupancy must stay within 0..4.
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            assert ({1'b0, pop_n} <= count_reg);
            assert (level <= 4'd4);
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// -----------------------------------------------------------------------------
// tb_fetch_align
//
// Directed bench for fetch_align. A one-cycle-latency memory model answers
// every request; each scenario task drives its stimulus and compares the
// observed outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_compressed;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
    } obs_t;

    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    fetch_align #(.RESET_PC(32'h0000_0080)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_compressed (out_compressed)
    );

    // Memory: responds exactly one cycle after each request; unset words read
    // as a 32-bit NOP.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= mem.exists(imem_addr) ? mem[imem_addr] : 32'h0000_0013;
    end

    function automatic obs_t obs();
        obs_t o;
        o.v     = out_valid;
        o.pc    = out_pc;
        o.instr = out_instr;
        o.c     = out_compressed;
        return o;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        cyc(); smp();
        cyc(); smp();
        got = obs();
        checks++;
        if (got !== obs_t'({1'b0, 32'h80, 32'h0, 1'b0}))
            $display("FAIL reset_outputs got %h want %h", got, obs_t'({1'b0, 32'h80, 32'h0, 1'b0}));
        else passes++;
        checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", imem_req);
        else passes++;
        // First cycle out of reset
        cyc(); rst = 1'b0; out_ready = 1'b1; smp();
        got = obs();
        checks++;
        if (got !== obs_t'({1'b0, 32'h80, 32'h0, 1'b0}))
            $display("FAIL post_reset_outputs got %h want %h", got, obs_t'({1'b0, 32'h80, 32'h0, 1'b0}));
        else passes++;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80)
            $display("FAIL post_reset_fetch got req=%0b addr=%h want req=1 addr=00000080", imem_req, imem_addr);
        else passes++;
        $display("reset: done");
    endtask

    task automatic test_basic();
        obs_t got;
        obs_t exp [2];
        exp[0] = {1'b1, 32'h80, 32'h0000_0013, 1'b0};
        exp[1] = {1'b1, 32'h84, 32'h0010_0093, 1'b0};
        cyc(); smp();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_latency got v=%0b want 0", out_valid);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            cyc(); smp();
            got = obs();
            checks++;
            if (got !== exp[k]) $display("FAIL basic[%0d] got %h want %h", k, got, exp[k]);
            else passes++;
            $display("basic: pc=%h instr=%h c=%0b", got.pc, got.instr, got.c);
        end
    endtask

    task automatic test_mixed();
        obs_t got;
        obs_t exp [3];
        exp[0] = {1'b1, 32'h0, 32'h0000_4501, 1'b1};
        exp[1] = {1'b1, 32'h2, 32'h0000_0093, 1'b0};
        exp[2] = {1'b1, 32'h6, 32'h0000_4585, 1'b1};
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0; smp();
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL mixed_redirect got v=%0b req=%0b addr=%h want v=0 req=1 addr=00000000",
                     out_valid, imem_req, imem_addr);
        else passes++;
        cyc(); redirect_valid = 1'b0; smp();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL mixed_latency got v=%0b want 0", out_valid);
        else passes++;
        for (int k = 0; k < 3; k++) begin
            cyc(); smp();
            got = obs();
            checks++;
            if (got !== exp[k]) $display("FAIL mixed[%0d] got %h want %h", k, got, exp[k]);
            else passes++;
            $display("mixed: pc=%h instr=%h c=%0b", got.pc, got.instr, got.c);
        end
    endtask

    task automatic test_redirect();
        obs_t got;
        obs_t exp [2];
        exp[0] = {1'b1, 32'h102, 32'h0000_0001, 1'b1};
        exp[1] = {1'b1, 32'h104, 32'h0000_0013, 1'b0};
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h40; smp();
        checks++;
        if (imem_addr !== 32'h40) $display("FAIL redir_first_addr got %h want 00000040", imem_addr);
        else passes++;
        // 0x40 request is in flight; redirect again
        cyc(); redirect_pc = 32'h102; smp();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL redir_addr got req=%0b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
        else passes++;
        cyc(); redirect_valid = 1'b0; smp();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL redir_latency got v=%0b want 0", out_valid);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            cyc(); smp();
            got = obs();
            checks++;
            if (got !== exp[k]) $display("FAIL redir[%0d] got %h want %h", k, got, exp[k]);
            else passes++;
            $display("redirect: pc=%h instr=%h c=%0b", got.pc, got.instr, got.c);
        end
    endtask

    task automatic test_backpressure();
        obs_t got;
        obs_t hold;
        obs_t exp [4];
        hold   = {1'b1, 32'h200, 32'h1111_0013, 1'b0};
        exp[0] = hold;
        exp[1] = {1'b1, 32'h204, 32'h2222_0013, 1'b0};
        exp[2] = {1'b1, 32'h208, 32'h3333_0013, 1'b0};
        exp[3] = {1'b1, 32'h20C, 32'h4444_0013, 1'b0};
        cyc(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; smp();
        cyc(); redirect_valid = 1'b0; smp();
        for (int i = 0; i < 10; i++) begin
            cyc(); smp();
            got = obs();
            checks++;
            if (got !== hold || imem_req !== 1'b0)
                $display("FAIL bp_hold[%0d] got %h req=%0b want %h req=0", i, got, imem_req, hold);
            else passes++;
            $display("backpressure: stall %0d pc=%h req=%0b", i, got.pc, imem_req);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(); out_ready = 1'b1; smp();
            got = obs();
            checks++;
            if (got !== exp[k]) $display("FAIL bp_release[%0d] got %h want %h", k, got, exp[k]);
            else passes++;
            $display("backpressure: pc=%h instr=%h", got.pc, got.instr);
        end
    endtask

    task automatic test_redirect_ready();
        obs_t got;
        obs_t exp;
        exp = {1'b1, 32'h300, 32'h5555_0013, 1'b0};
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1; smp();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rr_valid got v=%0b want 0", out_valid);
        else passes++;
        cyc(); redirect_valid = 1'b0; smp();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rr_latency got v=%0b want 0", out_valid);
        else passes++;
        cyc(); smp();
        got = obs();
        checks++;
        if (got !== exp) $display("FAIL rr_target got %h want %h", got, exp);
        else passes++;
        $display("redirect_ready: pc=%h instr=%h", got.pc, got.instr);
    endtask

    task automatic test_reset_mid();
        obs_t got;
        obs_t rexp;
        obs_t exp;
        rexp = {1'b0, 32'h80, 32'h0, 1'b0};
        exp  = {1'b1, 32'h80, 32'h0000_0013, 1'b0};
        cyc(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400; smp();
        cyc(); redirect_valid = 1'b0; smp();
        // Queue holds the 0x400 word; the 0x404 request is in flight
        cyc(); rst = 1'b1; smp();
        got = obs();
        checks++;
        if (got !== rexp || imem_req !== 1'b0)
            $display("FAIL mid_reset got %h req=%0b want %h req=0", got, imem_req, rexp);
        else passes++;
        cyc(); rst = 1'b0; out_ready = 1'b1; smp();
        got = obs();
        checks++;
        if (got !== rexp || imem_req !== 1'b1 || imem_addr !== 32'h80)
            $display("FAIL mid_restart got %h req=%0b addr=%h want %h req=1 addr=00000080",
                     got, imem_req, imem_addr, rexp);
        else passes++;
        cyc(); smp();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_latency got v=%0b want 0", out_valid);
        else passes++;
        cyc(); smp();
        got = obs();
        checks++;
        if (got !== exp) $display("FAIL mid_first got %h want %h", got, exp);
        else passes++;
        $display("reset_mid: pc=%h instr=%h", got.pc, got.instr);
    endtask

    initial begin
        mem[32'h080] = 32'h0000_0013;
        mem[32'h084] = 32'h0010_0093;
        mem[32'h000] = 32'h0093_4501;
        mem[32'h004] = 32'h4585_0000;
        mem[32'h040] = 32'hDEAD_BEEF;
        mem[32'h100] = 32'h0001_0001;
        mem[32'h200] = 32'h1111_0013;
        mem[32'h204] = 32'h2222_0013;
        mem[32'h208] = 32'h3333_0013;
        mem[32'h20C] = 32'h4444_0013;
        mem[32'h300] = 32'h5555_0013;
        mem[32'h400] = 32'h6666_0013;
        mem[32'h404] = 32'h7777_0013;

        test_reset();
        test_basic();
        test_mixed();
        test_redirect();
        test_backpressure();
        test_redirect_ready();
        test_reset_mid();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
